axis_frame_conform: RTL and testbench
=====================================

Name: axis_frame_conform

Overview:
- Parametrised successor to the fixed-64-bit padder in the PAICORE datapath AXI-Stream chain.
- Forces every frame to exactly the configured beat count:
  - short frames are padded with PAD_VALUE beats;
  - long frames are truncated, with the excess input beats dropped (when truncation is enabled).
- Output goes through a registered skid stage for timing closure, and the block reports per-class frame statistics.
- Sits between the DMA read stream and the PAICORE input formatter.

Parameters:
- DATA_W, 64: tdata width in bits.
- CNT_W, 32: width of the frame-length config and all beat/frame counters.
- PAD_VALUE, {DATA_W{1'b0}}: tdata value driven on pad beats.
- TRUNC_EN, 1: 1 enables truncation and drop of excess beats; 0 forwards long frames unchanged.

Ports:
- s_axis_aclk  in  1  single clock for all logic.
- s_axis_areset  in  1  synchronous, active-high reset.
- cfg_frame_len  in  CNT_W  target beats per frame; 0 = bypass, no padding or truncation.
- s_axis_tready  out  1  input ready.
- s_axis_tdata  in  DATA_W  input data.
- s_axis_tlast  in  1  input end of frame.
- s_axis_tvalid  in  1  input valid.
- m_axis_tready  in  1  output ready.
- m_axis_tdata  out  DATA_W  output data.
- m_axis_tlast  out  1  output end of frame, asserted exactly on beat cfg_frame_len.
- m_axis_tvalid  out  1  output valid.
- m_axis_hsked  out  1  m_axis_tvalid & m_axis_tready.
- stat_padded  out  CNT_W  count of frames that received pad beats; wraps.
- stat_truncated  out  CNT_W  count of frames that had beats dropped; wraps.
- busy  out  1  high while state is not PASS or the frame beat index is not 1.

Behaviour:
- Reset (s_axis_areset=1 at a clock edge):
  - state=PASS, beat_idx=1, skid stage empty;
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0 while reset is asserted;
  - stats=0.
  - Reset mid-frame discards the partial frame and any held beat; no tlast is emitted for it.
- Target latching:
  - tgt is latched from cfg_frame_len on the first accepted input beat of a frame (beat_idx==1).
  - Changes to cfg_frame_len mid-frame have no effect until the next frame.
- Core FSM produces one beat per cycle into the skid stage when the stage can accept (core_ready).
- PASS:
  - s_axis_tready = core_ready.
  - Each accepted beat is forwarded and beat_idx is incremented.
  - When an accepted beat is the input tlast:
    - beat_idx<tgt: forward with tlast=0, go to PAD.
    - beat_idx==tgt: forward with tlast=1.
    - beat_idx>tgt (only possible with TRUNC_EN=0): forward with tlast=1.
  - When an accepted beat is not the input tlast and beat_idx==tgt:
    - TRUNC_EN=1: forward with tlast=1, go to DROP.
    - TRUNC_EN=0: forward with tlast=0 and continue.
  - Any output tlast returns beat_idx to 1.
- PAD:
  - s_axis_tready=0.
  - Emits PAD_VALUE beats; tlast=1 on the beat with beat_idx==tgt, then back to PASS.
  - stat_padded increments once, on entry to PAD.
- DROP:
  - s_axis_tready=1; the skid stage is not written.
  - Discards beats up to and including the input tlast, then back to PASS with beat_idx=1.
  - stat_truncated increments once, on entry to DROP.
- tgt==0 (bypass): pure passthrough; tlast follows input; no PAD/DROP.
- tgt==1:
  - a 1-beat frame passes unchanged;
  - with TRUNC_EN=1, a longer frame emits beat 1 with tlast, then DROP.
- Skid stage:
  - Two-entry register slice; latency 1 cycle input→output.
  - Full throughput under continuous ready.
  - core_ready = !skid_full (registered, no combinational path from m_axis_tready to s_axis_tready).
- Handshake rules:
  - m_axis_* is stable while m_axis_tvalid & !m_axis_tready (AXIS compliant).
  - No beat is lost or duplicated under arbitrary backpressure.
- Counters are CNT_W wide and wrap.
- tgt = 2^CNT_W-1 must work with no overflow of beat_idx before tlast.

Decomposition:
- Package axis_conform_pkg: state enum (PASS, PAD, DROP), CNT_W default, bypass encoding constant (0).
- Sub-module axis_reg_slice (DATA_W+1 payload, skid buffer); reusable by other axis_ip blocks.

Test Plan:
- DATA_W=64, tgt=8, 5-beat input frame D0..D4 → outputs D0..D4 then 3 beats of 0, tlast only on beat 8; stat_padded=1; s_axis_tready low during the 3 pad cycles.
- tgt=4, TRUNC_EN=1, 7-beat frame → 4 beats out with tlast on beat 4; input beats 5–7 consumed with no output; stat_truncated=1; the next frame starts cleanly at beat_idx=1.
- tgt=4, TRUNC_EN=0, 7-beat frame → 7 beats out, tlast on beat 7; stats unchanged.
- Random m_axis_tready (50%) and random s_axis_tvalid, 1000 frames of length 1..16, tgt=10 → scoreboard matches the reference model exactly; no AXIS stability violations; throughput = 1 beat/cycle when both sides are always ready.
- cfg_frame_len changed from 8 to 3 after beat 2 of a frame → that frame is padded to 8; the following frame uses 3. cfg_frame_len=0 → 6-beat frame passes unchanged.
- Assert s_axis_areset during PAD beat 2 of 3 → m_axis_tvalid=0 the cycle after; next frame begins at beat 1; stats=0.

Source files
------------

// File: rtl/axis_conform_pkg.sv
// Shared types and constants for the AXI-Stream frame conformer.
package axis_conform_pkg;

    // Default width of the frame-length config and all counters.
    localparam int CNT_W_DEF = 32;

    // cfg_frame_len value that disables padding and truncation.
    localparam int BYPASS_LEN = 0;

    // Core sequencer states.
    typedef enum logic [1:0] {
        ST_PASS = 2'd0,  // forwarding input beats
        ST_PAD  = 2'd1,  // generating pad beats up to the target length
        ST_DROP = 2'd2   // swallowing excess input beats until input tlast
    } conform_state_e;

endpackage : axis_conform_pkg

// File: rtl/axis_reg_slice.sv
// Two-entry AXI-Stream register slice (skid buffer).
// One cycle of latency, full throughput, and the upstream ready is a flop,
// so there is no combinational path from out_ready_i to in_ready_o.
module axis_reg_slice #(
    parameter int PAYLOAD_W = 65
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PAYLOAD_W-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PAYLOAD_W-1:0] out_data_o
);

    logic                 out_valid_q, out_valid_d;
    logic [PAYLOAD_W-1:0] out_data_q,  out_data_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [PAYLOAD_W-1:0] skid_data_q,  skid_data_d;
    logic                 ready_q, ready_d;
    logic                 in_fire;

    assign in_ready_o  = ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign in_fire     = in_valid_i & ready_q;

    // Next-state: refill the output register from the skid entry first,
    // otherwise from the input; park the input in the skid entry when stalled.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (out_ready_i || !out_valid_q) begin
            if (skid_valid_q) begin
                // ready_q is low whenever the skid entry is full, so no input here
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_data_d = in_data_i;
                end
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
        ready_d = !skid_valid_d;
    end

    // State registers; reset empties both entries and holds ready low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ready_d;
        end
    end

endmodule : axis_reg_slice

// File: rtl/axis_frame_conform.sv
// AXI-Stream frame length conformer: pads short frames with PAD_VALUE beats
// and (optionally) truncates long frames so every frame carries exactly the
// configured number of beats. Output is registered through a skid slice.
module axis_frame_conform
    import axis_conform_pkg::*;
#(
    parameter int              DATA_W    = 64,
    parameter int              CNT_W     = CNT_W_DEF,
    parameter logic [DATA_W-1:0] PAD_VALUE = '0,
    parameter bit              TRUNC_EN  = 1'b1
) (
    input  logic              s_axis_aclk,
    input  logic              s_axis_areset,
    input  logic [CNT_W-1:0]  cfg_frame_len,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    output logic              m_axis_hsked,
    output logic [CNT_W-1:0]  stat_padded,
    output logic [CNT_W-1:0]  stat_truncated,
    output logic              busy
);

    localparam logic [CNT_W-1:0] IDX_FIRST = CNT_W'(1);

    conform_state_e    state_q, state_d;
    logic [CNT_W-1:0]  beat_idx_q, beat_idx_d;
    logic [CNT_W-1:0]  tgt_q, tgt_d;
    logic [CNT_W-1:0]  stat_pad_q, stat_pad_d;
    logic [CNT_W-1:0]  stat_trunc_q, stat_trunc_d;

    // Beat presented to the skid slice by the sequencer.
    logic              core_valid;
    logic              core_ready;
    logic              core_last;
    logic [DATA_W-1:0] core_data;

    logic              first_beat;
    logic [CNT_W-1:0]  cur_tgt;
    logic              bypass;
    logic              in_fire;
    logic              short_end;
    logic              long_cut;
    logic [DATA_W:0]   slice_out;

    // On the first beat of a frame the live config is the target; after that
    // the latched copy is used so mid-frame config writes are ignored.
    assign first_beat = (beat_idx_q == IDX_FIRST);
    assign cur_tgt    = first_beat ? cfg_frame_len : tgt_q;
    assign bypass     = (cur_tgt == CNT_W'(BYPASS_LEN));
    assign in_fire    = s_axis_tvalid & s_axis_tready;

    // Frame ended early: needs padding. Frame reached target without tlast:
    // needs truncation. Neither applies in bypass.
    assign short_end  = !bypass && s_axis_tlast && (beat_idx_q < cur_tgt);
    assign long_cut   = !bypass && !s_axis_tlast && TRUNC_EN && (beat_idx_q == cur_tgt);

    // Sequencer next-state, beat generation and statistics.
    always_comb begin
        state_d       = state_q;
        beat_idx_d    = beat_idx_q;
        tgt_d         = tgt_q;
        stat_pad_d    = stat_pad_q;
        stat_trunc_d  = stat_trunc_q;
        s_axis_tready = 1'b0;
        core_valid    = 1'b0;
        core_data     = s_axis_tdata;
        core_last     = 1'b0;
        unique case (state_q)
            ST_PASS: begin
                s_axis_tready = core_ready;
                core_valid    = s_axis_tvalid;
                if (bypass) begin
                    core_last = s_axis_tlast;
                end else if (s_axis_tlast) begin
                    // beat_idx > tgt only happens when long frames are forwarded
                    core_last = (beat_idx_q >= cur_tgt);
                end else begin
                    core_last = long_cut;
                end
                if (in_fire) begin
                    if (first_beat) begin
                        tgt_d = cfg_frame_len;
                    end
                    beat_idx_d = core_last ? IDX_FIRST : beat_idx_q + CNT_W'(1);
                    if (short_end) begin
                        state_d    = ST_PAD;
                        stat_pad_d = stat_pad_q + CNT_W'(1);
                    end else if (long_cut) begin
                        state_d      = ST_DROP;
                        stat_trunc_d = stat_trunc_q + CNT_W'(1);
                    end
                end
            end
            ST_PAD: begin
                core_valid = 1'b1;
                core_data  = PAD_VALUE;
                core_last  = (beat_idx_q == tgt_q);
                if (core_ready) begin
                    if (core_last) begin
                        state_d    = ST_PASS;
                        beat_idx_d = IDX_FIRST;
                    end else begin
                        beat_idx_d = beat_idx_q + CNT_W'(1);
                    end
                end
            end
            ST_DROP: begin
                // beat_idx is already back at 1 from the truncating tlast
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = ST_PASS;
                end
            end
            default: begin
                state_d    = ST_PASS;
                beat_idx_d = IDX_FIRST;
            end
        endcase
    end

    // Sequencer registers; reset abandons any partial frame.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state_q      <= ST_PASS;
            beat_idx_q   <= IDX_FIRST;
            tgt_q        <= '0;
            stat_pad_q   <= '0;
            stat_trunc_q <= '0;
        end else begin
            state_q      <= state_d;
            beat_idx_q   <= beat_idx_d;
            tgt_q        <= tgt_d;
            stat_pad_q   <= stat_pad_d;
            stat_trunc_q <= stat_trunc_d;
        end
    end

    axis_reg_slice #(
        .PAYLOAD_W (DATA_W + 1)
    ) u_slice (
        .clk_i       (s_axis_aclk),
        .rst_i       (s_axis_areset),
        .in_valid_i  (core_valid),
        .in_ready_o  (core_ready),
        .in_data_i   ({core_last, core_data}),
        .out_valid_o (m_axis_tvalid),
        .out_ready_i (m_axis_tready),
        .out_data_o  (slice_out)
    );

    assign m_axis_tlast   = slice_out[DATA_W];
    assign m_axis_tdata   = slice_out[DATA_W-1:0];
    assign m_axis_hsked   = m_axis_tvalid & m_axis_tready;
    assign stat_padded    = stat_pad_q;
    assign stat_truncated = stat_trunc_q;
    assign busy           = (state_q != ST_PASS) || (beat_idx_q != IDX_FIRST);

endmodule : axis_frame_conform

// File: tb/tb_axis_frame_conform.sv
// Bench for axis_frame_conform: two instances (truncating and forwarding),
// frame-level reference model feeding per-instance expectation queues,
// and an independent output monitor.
module tb_axis_frame_conform;

    localparam int DW = 64;
    localparam int CW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          areset;
    logic [CW-1:0] cfg      [2];
    logic          s_tready [2];
    logic [DW-1:0] s_tdata  [2];
    logic          s_tlast  [2];
    logic          s_tvalid [2];
    logic          m_tready [2];
    logic [DW-1:0] m_tdata  [2];
    logic          m_tlast  [2];
    logic          m_tvalid [2];
    logic          m_hsked  [2];
    logic [CW-1:0] st_pad   [2];
    logic [CW-1:0] st_trunc [2];
    logic          busy     [2];

    axis_frame_conform #(.DATA_W(DW), .CNT_W(CW), .PAD_VALUE('0), .TRUNC_EN(1'b1)) dut_t (
        .s_axis_aclk(clk), .s_axis_areset(areset), .cfg_frame_len(cfg[0]),
        .s_axis_tready(s_tready[0]), .s_axis_tdata(s_tdata[0]), .s_axis_tlast(s_tlast[0]),
        .s_axis_tvalid(s_tvalid[0]), .m_axis_tready(m_tready[0]), .m_axis_tdata(m_tdata[0]),
        .m_axis_tlast(m_tlast[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_hsked(m_hsked[0]),
        .stat_padded(st_pad[0]), .stat_truncated(st_trunc[0]), .busy(busy[0]));

    axis_frame_conform #(.DATA_W(DW), .CNT_W(CW), .PAD_VALUE('0), .TRUNC_EN(1'b0)) dut_f (
        .s_axis_aclk(clk), .s_axis_areset(areset), .cfg_frame_len(cfg[1]),
        .s_axis_tready(s_tready[1]), .s_axis_tdata(s_tdata[1]), .s_axis_tlast(s_tlast[1]),
        .s_axis_tvalid(s_tvalid[1]), .m_axis_tready(m_tready[1]), .m_axis_tdata(m_tdata[1]),
        .m_axis_tlast(m_tlast[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_hsked(m_hsked[1]),
        .stat_padded(st_pad[1]), .stat_truncated(st_trunc[1]), .busy(busy[1]));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mpad   [2];
    int mtrunc [2];
    bit rmode = 1'b0;   // 1: random output backpressure
    logic [DW:0] q0[$];
    logic [DW:0] q1[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [DW:0] act, input logic [DW:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic void push_exp(int u, logic [DW:0] v);
        if (u == 0) q0.push_back(v); else q1.push_back(v);
    endfunction

    function automatic int qsize(int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [DW:0] pop_exp(int u);
        if (u == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // Output backpressure driver.
    initial begin
        m_tready[0] = 1'b1;
        m_tready[1] = 1'b1;
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++)
                m_tready[u] = rmode ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    // Monitor: compares every output handshake against the expectation
    // queue and checks that a stalled beat is held steady.
    initial begin
        logic        pv [2];
        logic [DW:0] pd [2];
        logic [DW:0] e;
        pv[0] = 1'b0; pv[1] = 1'b0;
        pd[0] = '0;   pd[1] = '0;
        forever begin
            @(negedge clk);
            #1;
            for (int u = 0; u < 2; u++) begin
                if (areset) begin
                    pv[u] = 1'b0;
                end else begin
                    if (pv[u]) begin
                        chk("hold_valid", {64'd0, m_tvalid[u]}, 65'd1);
                        chk("hold_payload", {m_tlast[u], m_tdata[u]}, pd[u]);
                    end
                    if (m_tvalid[u] && m_tready[u]) begin
                        if (qsize(u) == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_beat u=%0d actual=%0h required=none", u,
                                     {m_tlast[u], m_tdata[u]});
                        end else begin
                            e = pop_exp(u);
                            chk($sformatf("beat_u%0d", u), {m_tlast[u], m_tdata[u]}, e);
                        end
                    end
                    chk("hsked", {64'd0, m_hsked[u]}, {64'd0, m_tvalid[u] & m_tready[u]});
                    pv[u] = m_tvalid[u] & !m_tready[u];
                    pd[u] = {m_tlast[u], m_tdata[u]};
                end
            end
        end
    end

    // One input beat; called and returns on a falling edge.
    task automatic send_beat(input int u, input logic [DW-1:0] d, input logic l);
        int g = 0;
        s_tdata[u]  = d;
        s_tlast[u]  = l;
        s_tvalid[u] = 1'b1;
        while (!s_tready[u]) begin
            @(negedge clk);
            g++;
            if (g > 4000) begin
                total++;
                bad++;
                $display("FAIL send_timeout u=%0d actual=stalled required=accepted", u);
                $display("test done: total=%0d bad=%0d", total, bad);
                $fatal(1, "input stalled");
            end
        end
        @(negedge clk);
        s_tvalid[u] = 1'b0;
    endtask

    // Send one frame of n random beats with target cfgv; optionally rewrite
    // the config before beat index chg_at. Expected output is derived from
    // the frame-level rules: resulting length and which class it falls in.
    task automatic send_frame(input int u, input int n, input int cfgv,
                              input int chg_at, input int chg_val, input int gap);
        logic [DW-1:0] fb [64];
        int  olen;
        bit  trunc;
        trunc = (u == 0);
        cfg[u] = CW'(cfgv);
        for (int i = 0; i < n; i++) fb[i] = {$urandom, $urandom};
        if (cfgv == 0)       olen = n;
        else if (n < cfgv)   olen = cfgv;
        else if (trunc)      olen = cfgv;
        else                 olen = n;
        if (cfgv != 0 && n < cfgv) mpad[u]++;
        if (cfgv != 0 && n > cfgv && trunc) mtrunc[u]++;
        for (int k = 0; k < olen; k++)
            push_exp(u, {k == olen - 1, (k < n) ? fb[k] : 64'd0});
        for (int i = 0; i < n; i++) begin
            if (i == chg_at) cfg[u] = CW'(chg_val);
            while (int'($urandom_range(99)) < gap) @(negedge clk);
            send_beat(u, fb[i], i == n - 1);
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((qsize(0) != 0 || qsize(1) != 0) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        chk("drain_in_time", {64'd0, g < 5000}, 65'd1);
    endtask

    task automatic check_idle();
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("stat_padded_u%0d", u), {33'd0, st_pad[u]}, 65'(mpad[u]));
            chk($sformatf("stat_truncated_u%0d", u), {33'd0, st_trunc[u]}, 65'(mtrunc[u]));
            chk($sformatf("busy_idle_u%0d", u), {64'd0, busy[u]}, 65'd0);
            chk($sformatf("tvalid_idle_u%0d", u), {64'd0, m_tvalid[u]}, 65'd0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        areset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            cfg[u] = '0; s_tdata[u] = '0; s_tlast[u] = 1'b0; s_tvalid[u] = 1'b0;
            mpad[u] = 0; mtrunc[u] = 0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_tvalid", {64'd0, m_tvalid[u]}, 65'd0);
            chk("rst_tlast",  {64'd0, m_tlast[u]}, 65'd0);
            chk("rst_tdata",  {1'b0, m_tdata[u]}, 65'd0);
            chk("rst_tready", {64'd0, s_tready[u]}, 65'd0);
            chk("rst_stats",  {1'b0, st_pad[u], st_trunc[u]}, 65'd0);
            chk("rst_busy",   {64'd0, busy[u]}, 65'd0);
        end
        areset = 1'b0;
        @(negedge clk);

        // Short frame: 5 beats padded to 8, input held off for the 3 pad cycles.
        send_frame(0, 5, 8, -1, 0, 0);
        chk("busy_in_pad", {64'd0, busy[0]}, 65'd1);
        for (int i = 0; i < 3; i++) begin
            chk("tready_low_in_pad", {64'd0, s_tready[0]}, 65'd0);
            @(negedge clk);
        end
        chk("tready_after_pad", {64'd0, s_tready[0]}, 65'd1);
        drain();
        check_idle();

        // Long frame truncated to 4, then a clean 4-beat frame.
        send_frame(0, 7, 4, -1, 0, 0);
        send_frame(0, 4, 4, -1, 0, 0);
        // Long frame forwarded unchanged when truncation is off.
        send_frame(1, 7, 4, -1, 0, 0);
        drain();
        check_idle();

        // Mid-frame config change only affects the next frame; bypass; tgt=1.
        send_frame(0, 5, 8, 2, 3, 0);
        send_frame(0, 5, 3, -1, 0, 0);
        send_frame(0, 6, 0, -1, 0, 0);
        send_frame(1, 6, 0, -1, 0, 0);
        send_frame(0, 1, 1, -1, 0, 0);
        send_frame(0, 3, 1, -1, 0, 0);
        send_frame(1, 3, 1, -1, 0, 0);
        drain();
        check_idle();

        // Throughput: 10 beats accepted in 10 consecutive cycles.
        t0 = cyc;
        send_frame(0, 10, 10, -1, 0, 0);
        chk("throughput_cycles", 65'(cyc - t0), 65'd10);
        drain();
        check_idle();

        // Randomized traffic under 50% output backpressure.
        rmode = 1'b1;
        for (int f = 0; f < 1000; f++) send_frame(0, $urandom_range(16, 1), 10, -1, 0, 30);
        drain();
        check_idle();
        for (int f = 0; f < 150; f++) send_frame(1, $urandom_range(16, 1), 10, -1, 0, 30);
        for (int f = 0; f < 200; f++) send_frame(0, $urandom_range(16, 1), $urandom_range(12), -1, 0, 20);
        drain();
        check_idle();
        rmode = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during the second of three pad beats.
        send_frame(0, 5, 8, -1, 0, 0);
        @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        chk("rst_mid_tvalid", {64'd0, m_tvalid[0]}, 65'd0);
        chk("rst_mid_stats", {1'b0, st_pad[0], st_trunc[0]}, 65'd0);
        chk("rst_mid_tready", {64'd0, s_tready[0]}, 65'd0);
        q0.delete();
        q1.delete();
        for (int u = 0; u < 2; u++) begin mpad[u] = 0; mtrunc[u] = 0; end
        @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", {64'd0, busy[0]}, 65'd0);
        send_frame(0, 3, 3, -1, 0, 0);
        send_frame(0, 2, 4, -1, 0, 0);
        drain();
        check_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_axis_frame_conform
